// File: rtl/light_mode_controller.sv
// Lamp controller: one push button (short press toggles the lamp, long press toggles
// auto/manual mode), presence sensor and auto-shutdown timer, as a registered Moore FSM.
module light_mode_controller #(
  parameter int DEBOUNCE_T = 100,
  parameter int SWITCH_T   = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  input  logic infravermelho,
  input  logic timeout,
  output logic lamp,
  output logic timer_enable,
  output logic manual_mode
);

  // One-hot encoding leaves spare codes, so a corrupted register is detectable.
  typedef enum logic [3:0] {
    AUTO_OFF   = 4'b0001,
    AUTO_ON    = 4'b0010,
    MANUAL_OFF = 4'b0100,
    MANUAL_ON  = 4'b1000
  } state_t;

  localparam logic [15:0] DEB_LIM = 16'(DEBOUNCE_T);
  localparam logic [15:0] SW_LIM  = 16'(SWITCH_T);
  localparam logic [15:0] SW_M1   = 16'(SWITCH_T - 1);

  state_t      state;
  state_t      nxt;
  logic [15:0] tp;
  logic        long_press;
  logic        short_press;
  logic        legal;

  assign long_press  = push_button && (tp == SW_M1);
  assign short_press = !push_button && (tp >= DEB_LIM) && (tp < SW_LIM);
  assign legal       = state inside {AUTO_OFF, AUTO_ON, MANUAL_OFF, MANUAL_ON};

  function automatic state_t next_state(input state_t s, input logic lp, input logic sp,
                                        input logic ir, input logic to);
    case (s)
      AUTO_OFF:   next_state = lp ? MANUAL_OFF : (sp || ir) ? AUTO_ON  : AUTO_OFF;
      AUTO_ON:    next_state = lp ? MANUAL_ON  : (sp || to) ? AUTO_OFF : AUTO_ON;
      MANUAL_OFF: next_state = lp ? AUTO_OFF   : sp ? MANUAL_ON  : MANUAL_OFF;
      MANUAL_ON:  next_state = lp ? AUTO_ON    : sp ? MANUAL_OFF : MANUAL_ON;
      default:    next_state = AUTO_OFF;
    endcase
  endfunction

  assign nxt = next_state(state, long_press, short_press, infravermelho, timeout);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= AUTO_OFF;
      tp           <= '0;
      lamp         <= 1'b0;
      timer_enable <= 1'b0;
      manual_mode  <= 1'b0;
    end else begin
      state        <= nxt;
      lamp         <= (nxt == AUTO_ON) || (nxt == MANUAL_ON);
      timer_enable <= (nxt == AUTO_ON);
      manual_mode  <= (nxt == MANUAL_OFF) || (nxt == MANUAL_ON);
      if (!legal || !push_button)
        tp <= '0;
      else if (tp != SW_LIM)
        tp <= tp + 16'd1;
    end
  end

endmodule

// File: tb/tb_light_mode_controller.sv
// Randomized and directed bench for light_mode_controller against a behavioural model
// that tracks only "lamp on" and "manual mode" flags plus a press length.
module tb_light_mode_controller;

  localparam int DEB = 4;
  localparam int SW  = 20;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b1;
  logic push_button = 1'b0;
  logic infravermelho = 1'b0;
  logic timeout = 1'b0;
  logic lamp, timer_enable, manual_mode;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  bit m_lamp   = 1'b0;
  bit m_manual = 1'b0;
  int m_held   = 0;

  light_mode_controller #(.DEBOUNCE_T(DEB), .SWITCH_T(SW)) dut (
    .clk(clk), .rst(rst), .push_button(push_button), .infravermelho(infravermelho),
    .timeout(timeout), .lamp(lamp), .timer_enable(timer_enable), .manual_mode(manual_mode)
  );

  initial forever #5 clk = clk_en ? ~clk : clk;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got {lamp,timer_enable,manual_mode}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_out();
    return {m_lamp, m_lamp && !m_manual, m_manual};
  endfunction

  function automatic logic [2:0] dut_out();
    return {lamp, timer_enable, manual_mode};
  endfunction

  // Apply one clock of inputs from the falling edge, update the model, check after.
  task automatic step(input bit pb, input bit ir, input bit to, input string tag);
    bit lp, sp;
    push_button = pb; infravermelho = ir; timeout = to;
    @(posedge clk);
    lp = pb && (m_held + 1 == SW);
    sp = !pb && (m_held >= DEB) && (m_held < SW);
    if (lp)      m_manual = !m_manual;
    else if (sp) m_lamp   = !m_lamp;
    else if (!m_manual) begin
      if (m_lamp && to)       m_lamp = 1'b0;
      else if (!m_lamp && ir) m_lamp = 1'b1;
    end
    m_held = pb ? ((m_held < SW) ? m_held + 1 : SW) : 0;
    @(negedge clk);
    check(tag, dut_out(), model_out());
  endtask

  task automatic hold(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, tag);
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    check(tag, dut_out(), 3'b000);
    m_lamp = 1'b0; m_manual = 1'b0; m_held = 0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_during"}, dut_out(), 3'b000);
    rst = 1'b0;
  endtask

  initial begin
    // Reset with no clock running.
    #3;
    check("reset_noclk", dut_out(), 3'b000);
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Presence turns lamp on in auto mode, timeout turns it off.
    step(0, 1, 0, "ir_on");      check("ir_on_exp", dut_out(), 3'b110);
    step(0, 0, 0, "ir_hold");    check("ir_hold_exp", dut_out(), 3'b110);
    step(0, 0, 1, "to_off");     check("to_off_exp", dut_out(), 3'b000);

    // Glitch vs. minimum short press.
    hold(DEB - 1, "glitch_hi");
    step(0, 0, 0, "glitch_rel"); check("glitch_exp", dut_out(), 3'b000);
    hold(DEB, "short_hi");       check("short_hi_exp", dut_out(), 3'b000);
    step(0, 0, 0, "short_rel");  check("short_on_exp", dut_out(), 3'b110);
    hold(DEB, "short2_hi");
    step(0, 0, 0, "short2_rel"); check("short_off_exp", dut_out(), 3'b000);

    // Long press into manual mode; sensors ignored there.
    hold(SW - 1, "long_pre");    check("long_pre_exp", dut_out(), 3'b000);
    hold(1, "long_edge");        check("long_edge_exp", dut_out(), 3'b001);
    hold(5, "long_over");        check("long_over_exp", dut_out(), 3'b001);
    step(0, 0, 0, "long_rel");   check("long_rel_exp", dut_out(), 3'b001);
    step(0, 1, 0, "man_ir");     check("man_ir_exp", dut_out(), 3'b001);
    step(0, 0, 1, "man_to");     check("man_to_exp", dut_out(), 3'b001);
    hold(SW, "back_auto");
    step(0, 0, 0, "back_rel");   check("back_auto_exp", dut_out(), 3'b000);

    // Reset mid-press discards the accumulated count.
    hold(10, "pre_rst");
    push_button = 1'b1;
    reset_pulse("mid_press_rst");
    hold(SW - 1, "post_rst");    check("post_rst_exp", dut_out(), 3'b000);
    hold(1, "post_rst_long");    check("post_rst_long_exp", dut_out(), 3'b001);
    step(0, 0, 0, "post_rst_rel");
    hold(SW, "back2");
    step(0, 0, 0, "back2_rel");  check("back2_exp", dut_out(), 3'b000);

    // Simultaneous events from AUTO_ON.
    step(0, 1, 0, "sim_on");     check("sim_on_exp", dut_out(), 3'b110);
    hold(5, "sim_short_hi");
    step(0, 0, 1, "sim_short_to"); check("short_beats_to", dut_out(), 3'b000);
    step(0, 1, 0, "sim_on2");    check("sim_on2_exp", dut_out(), 3'b110);
    hold(SW - 1, "sim_long_pre");
    step(1, 0, 1, "sim_long_to"); check("long_beats_to", dut_out(), 3'b101);
    step(0, 0, 0, "sim_long_rel"); check("sim_long_rel_exp", dut_out(), 3'b101);

    // Randomized runs of button presses with sensor noise and occasional resets.
    for (int r = 0; r < 400; r++) begin
      int len;
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk);
        reset_pulse("rand_rst");
      end
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(SW - 5, SW + 5) : $urandom_range(0, DEB + 3);
      for (int i = 0; i < len; i++)
        step(1'b1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, "rand_hi");
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++)
        step(1'b0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, "rand_lo");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
